// File: rtl/fp_addsub_control_pkg.sv
// Shared encodings and defaults for the FP add/sub sequencing controller.
package fp_addsub_control_pkg;

    localparam int EXP_W_DEF     = 8;
    localparam int MANT_W_DEF    = 23;
    localparam int ALIGN_SAT_DEF = 25;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_OPERATE,
        ST_NORMALIZE,
        ST_ROUND,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Only add and sub are handled by this datapath; mult and reserved are rejected.
    function automatic logic op_is_valid(input logic [1:0] op);
        return (op != OP_MUL) && (op != OP_RSV);
    endfunction

endpackage

// File: rtl/fp_addsub_control_if.sv
// Issue handshake plus datapath control/status bundle of the FP add/sub controller.
interface fp_addsub_control_if #(
    parameter int EXP_W = 8
);
    logic             start;
    logic [1:0]       op_in;
    logic [EXP_W-1:0] expDiff;
    logic             carry;
    logic             mant_msb;
    logic             mant_zero;
    logic             round_carry;

    logic             smallerExpSrc;
    logic [EXP_W-1:0] shiftRightQtt;
    logic [1:0]       operation;
    logic             normalization_src;
    logic             shift_src;
    logic             alu_we;
    logic             norm_en;
    logic             round_en;
    logic             busy;
    logic             done;
    logic             invalid_op;

    // The controller responds to requests, so it takes the slave side.
    modport slave (
        input  start, op_in, expDiff, carry, mant_msb, mant_zero, round_carry,
        output smallerExpSrc, shiftRightQtt, operation, normalization_src,
               shift_src, alu_we, norm_en, round_en, busy, done, invalid_op
    );

    modport master (
        output start, op_in, expDiff, carry, mant_msb, mant_zero, round_carry,
        input  smallerExpSrc, shiftRightQtt, operation, normalization_src,
               shift_src, alu_we, norm_en, round_en, busy, done, invalid_op
    );
endinterface

// File: rtl/fp_addsub_control_align.sv
// Alignment decode: picks the smaller-exponent operand and the saturated right-shift amount.
module fp_addsub_control_align #(
    parameter int EXP_W     = 8,
    parameter int ALIGN_SAT = 25
) (
    input  logic signed [EXP_W-1:0] exp_diff,
    output logic                    smaller_src,
    output logic        [EXP_W-1:0] shift_amt
);
    localparam logic [EXP_W:0] SAT_V = (EXP_W+1)'(ALIGN_SAT);

    logic               diff_neg;
    logic signed [EXP_W:0] diff_ext;
    logic signed [EXP_W:0] diff_abs;

    // One extra bit so that the most negative difference has a representable magnitude.
    assign diff_neg    = exp_diff[EXP_W-1];
    assign diff_ext    = {exp_diff[EXP_W-1], exp_diff};
    assign diff_abs    = diff_neg ? -diff_ext : diff_ext;
    assign smaller_src = ~diff_neg;
    assign shift_amt   = ($unsigned(diff_abs) > SAT_V) ? SAT_V[EXP_W-1:0]
                                                       : diff_abs[EXP_W-1:0];
endmodule

// File: rtl/fp_addsub_control.sv
// Multi-cycle sequencer for the single-precision add/sub datapath:
// align -> operate -> normalize -> round -> renormalize check -> done.
module fp_addsub_control
    import fp_addsub_control_pkg::*;
#(
    parameter int EXP_W     = EXP_W_DEF,
    parameter int MANT_W    = MANT_W_DEF,
    parameter int ALIGN_SAT = ALIGN_SAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    fp_addsub_control_if.slave bus
);
    localparam int                CNT_W   = $clog2(MANT_W + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MANT_W);

    state_t             state, state_nx;
    logic [1:0]         op_q;
    logic               invalid_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               small_src_q;
    logic [EXP_W-1:0]   shamt_q;

    logic               align_sel;
    logic [EXP_W-1:0]   align_amt;
    logic               cnt_inc;
    logic [1:0]         op_out;
    logic               alu_we, norm_en, shift_src, norm_src, round_en, done;

    fp_addsub_control_align #(
        .EXP_W     (EXP_W),
        .ALIGN_SAT (ALIGN_SAT)
    ) u_align (
        .exp_diff    (bus.expDiff),
        .smaller_src (align_sel),
        .shift_amt   (align_amt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            op_q        <= '0;
            invalid_q   <= 1'b0;
            cnt_q       <= '0;
            small_src_q <= 1'b0;
            shamt_q     <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && bus.start) begin
                op_q      <= bus.op_in;
                invalid_q <= ~op_is_valid(bus.op_in);
                cnt_q     <= '0;
            end
            if (state == ST_ALIGN) begin
                small_src_q <= align_sel;
                shamt_q     <= align_amt;
            end
            if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nx  = state;
        alu_we    = 1'b0;
        norm_en   = 1'b0;
        shift_src = 1'b0;
        norm_src  = 1'b0;
        round_en  = 1'b0;
        done      = 1'b0;
        cnt_inc   = 1'b0;
        op_out    = 2'b00;
        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nx = op_is_valid(bus.op_in) ? ST_ALIGN : ST_DONE;
                end
            end
            ST_ALIGN: begin
                state_nx = ST_OPERATE;
            end
            ST_OPERATE: begin
                alu_we   = 1'b1;
                op_out   = op_q;
                state_nx = ST_NORMALIZE;
            end
            ST_NORMALIZE: begin
                op_out = op_q;
                // A zero count means this is the first normalize cycle, the only one where carry matters.
                if (cnt_q == '0 && bus.carry) begin
                    shift_src = 1'b1;
                    norm_en   = 1'b1;
                    state_nx  = ST_ROUND;
                end else if (cnt_q == CNT_MAX) begin
                    state_nx = ST_ROUND;
                end else if (bus.mant_zero) begin
                    state_nx = ST_DONE;
                end else if (bus.mant_msb) begin
                    state_nx = ST_ROUND;
                end else begin
                    norm_en = 1'b1;
                    cnt_inc = 1'b1;
                end
            end
            ST_ROUND: begin
                round_en = 1'b1;
                op_out   = op_q;
                state_nx = ST_CHECK;
            end
            ST_CHECK: begin
                norm_src = 1'b1;
                op_out   = op_q;
                if (bus.round_carry) begin
                    shift_src = 1'b1;
                    norm_en   = 1'b1;
                end
                state_nx = ST_DONE;
            end
            ST_DONE: begin
                done     = 1'b1;
                op_out   = invalid_q ? 2'b00 : op_q;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign bus.smallerExpSrc     = small_src_q;
    assign bus.shiftRightQtt     = shamt_q;
    assign bus.operation         = op_out;
    assign bus.normalization_src = norm_src;
    assign bus.shift_src         = shift_src;
    assign bus.alu_we            = alu_we;
    assign bus.norm_en           = norm_en;
    assign bus.round_en          = round_en;
    assign bus.busy              = (state != ST_IDLE);
    assign bus.done              = done;
    assign bus.invalid_op        = (state == ST_DONE) && invalid_q;
endmodule
